// File: rtl/board_tile_sequencer.sv
// Board tile sequencer: walks every board cell, applies the cursor and miss-marker overlays,
// looks up the sprite ROM and hands 8x8 tiles downstream. Optional macro: CURSOR_BLINK_EN.
module board_tile_sequencer #(
  parameter int BOARD_DIM    = 10,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  CursorRow,
  input  logic [3:0]  CursorCol,
  output logic        BoardRdEn,
  output logic [6:0]  BoardAddr,
  input  logic [9:0]  BoardData,
  output logic [9:0]  RomData,
  input  logic [63:0] RomDotMatrix,
  output logic        TileValid,
  input  logic        TileReady,
  output logic [3:0]  TileRow,
  output logic [3:0]  TileCol,
  output logic [63:0] TileDots,
  output logic        FrameDone,
  output logic        Busy
);

  if (BOARD_DIM < 1 || BOARD_DIM > 11) begin : gBadBoardDim
    $error("board_tile_sequencer: BOARD_DIM must be within 1..11");
  end
  if (BLINK_FRAMES < 1) begin : gBadBlinkFrames
    $error("board_tile_sequencer: BLINK_FRAMES must be at least 1");
  end

  localparam logic [3:0] Dim     = 4'(BOARD_DIM);
  localparam logic [3:0] LastIdx = 4'(BOARD_DIM - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, LOOKUP, HOLD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [9:0]  romData_q, romData_d;
  logic        tileValid_q, tileValid_d;
  logic [3:0]  tileRow_q, tileRow_d;
  logic [3:0]  tileCol_q, tileCol_d;
  logic [63:0] tileDots_q, tileDots_d;
  logic        frameDone_q, frameDone_d;
  logic        frameEnd;
  logic        cursorOn;
  logic        cursorHit;
  logic        missHit;
  logic [6:0]  cellAddr;

  assign cellAddr  = 7'(row_q) * 7'(BOARD_DIM) + 7'(col_q);
  assign cursorHit = cursorOn && (CursorRow == row_q) && (CursorCol == col_q) &&
                     (CursorRow < Dim) && (CursorCol < Dim);
  assign missHit   = (BoardData[5:1] == 5'd0) && BoardData[0];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    romData_d   = romData_q;
    tileValid_d = tileValid_q;
    tileRow_d   = tileRow_q;
    tileCol_d   = tileCol_q;
    tileDots_d  = tileDots_q;
    frameDone_d = 1'b0;
    frameEnd    = 1'b0;
    case (state_q)
      // A Start landing on the FrameDone cycle belongs to the frame just finished.
      IDLE: begin
        if (Start && !frameDone_q) begin
          row_d   = '0;
          col_d   = '0;
          state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        if (cursorHit) begin
          romData_d = {BoardData[9:6], 5'b10001, BoardData[0]};
        end else if (missHit) begin
          romData_d = {BoardData[9:6], 5'b10010, 1'b1};
        end else begin
          romData_d = BoardData;
        end
        state_d = LOOKUP;
      end
      LOOKUP: begin
        tileDots_d  = RomDotMatrix;
        tileRow_d   = row_q;
        tileCol_d   = col_q;
        tileValid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (TileReady) begin
          tileValid_d = 1'b0;
          if ((row_q == LastIdx) && (col_q == LastIdx)) begin
            frameDone_d = 1'b1;
            frameEnd    = 1'b1;
            state_d     = IDLE;
          end else begin
            if (col_q == LastIdx) begin
              col_d = '0;
              row_d = row_q + 4'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      romData_q   <= '0;
      tileValid_q <= 1'b0;
      tileRow_q   <= '0;
      tileCol_q   <= '0;
      tileDots_q  <= '0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      romData_q   <= romData_d;
      tileValid_q <= tileValid_d;
      tileRow_q   <= tileRow_d;
      tileCol_q   <= tileCol_d;
      tileDots_q  <= tileDots_d;
      frameDone_q <= frameDone_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frameCnt_q, frameCnt_d;
  logic          cursorOn_q, cursorOn_d;

  // The cursor blink half-period is counted in completed frames only.
  always_comb begin
    frameCnt_d = frameCnt_q;
    cursorOn_d = cursorOn_q;
    if (frameEnd) begin
      if (frameCnt_q == FW'(BLINK_FRAMES - 1)) begin
        frameCnt_d = '0;
        cursorOn_d = ~cursorOn_q;
      end else begin
        frameCnt_d = frameCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      frameCnt_q <= '0;
      cursorOn_q <= 1'b1;
    end else begin
      frameCnt_q <= frameCnt_d;
      cursorOn_q <= cursorOn_d;
    end
  end

  assign cursorOn = cursorOn_q;
`else
  assign cursorOn = 1'b1;
`endif

  assign BoardRdEn = (state_q == READ);
  assign BoardAddr = (state_q == READ) ? cellAddr : 7'd0;
  assign RomData   = romData_q;
  assign TileValid = tileValid_q;
  assign TileRow   = tileRow_q;
  assign TileCol   = tileCol_q;
  assign TileDots  = tileDots_q;
  assign FrameDone = frameDone_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_board_tile_sequencer.sv
// Self-checking bench for board_tile_sequencer: board RAM and sprite ROM models plus a tile
// scoreboard. Define CURSOR_BLINK_EN to build both DUT and bench with the blinking cursor.
module tb_board_tile_sequencer;

`ifdef CURSOR_BLINK_EN
  localparam int  BlinkFrames = 2;
  localparam bit  BlinkOn     = 1'b1;
`else
  localparam int  BlinkFrames = 16;
  localparam bit  BlinkOn     = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  CursorRow;
  logic [3:0]  CursorCol;
  logic        BoardRdEn;
  logic [6:0]  BoardAddr;
  logic [9:0]  BoardData;
  logic [9:0]  RomData;
  logic [63:0] RomDotMatrix;
  logic        TileValid;
  logic        TileReady;
  logic [3:0]  TileRow;
  logic [3:0]  TileCol;
  logic [63:0] TileDots;
  logic        FrameDone;
  logic        Busy;

  board_tile_sequencer #(.BOARD_DIM(10), .BLINK_FRAMES(BlinkFrames)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .CursorRow(CursorRow), .CursorCol(CursorCol),
    .BoardRdEn(BoardRdEn), .BoardAddr(BoardAddr), .BoardData(BoardData),
    .RomData(RomData), .RomDotMatrix(RomDotMatrix),
    .TileValid(TileValid), .TileReady(TileReady),
    .TileRow(TileRow), .TileCol(TileCol), .TileDots(TileDots),
    .FrameDone(FrameDone), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
    logic [9:0] w;
  } tile_t;

  logic [9:0] boardMem [0:99];
  logic [9:0] seenRom  [0:99];
  tile_t      expQ[$];
  int         passCount = 0;
  int         failCount = 0;
  int         checkCount = 0;
  bit         cursorOnModel;
  int         frameCntModel;

  // Board RAM: one-cycle read latency.
  always @(posedge Clock) begin
    if (BoardRdEn) BoardData <= (BoardAddr < 7'd100) ? boardMem[BoardAddr] : 10'h3FF;
  end

  function automatic logic [63:0] romDots(input logic [9:0] w);
    return {w, ~w, w ^ 10'h155, {w[4:0], w[9:5]}, ~w ^ 10'h0F0, w ^ 10'h3C3, w[3:0]};
  endfunction

  assign RomDotMatrix = romDots(RomData);

  function automatic logic [9:0] expWord(input logic [9:0] w, input int r, input int c);
    if (cursorOnModel && int'(CursorRow) == r && int'(CursorCol) == c)
      return {w[9:6], 5'b10001, w[0]};
    else if (w[5:1] == 5'd0 && w[0])
      return {w[9:6], 5'b10010, 1'b1};
    else
      return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one frame from the current negedge; optional stall on one tile or reset on one tile.
  task automatic applyStimulus(input int stallRow, input int stallCol, input int stallCycles,
                               input int abortRow, input int abortCol);
    int          cyc;
    int          stallCnt;
    int          accepted;
    bit          done;
    bit          firstSeen;
    logic [71:0] held;
    tile_t       e;
    stallCnt  = 0;
    accepted  = 0;
    done      = 1'b0;
    firstSeen = 1'b0;
    held      = '0;
    for (int i = 0; i < 100; i++) seenRom[i] = 10'h3FF;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        e.r = 4'(r);
        e.c = 4'(c);
        e.w = expWord(boardMem[r*10+c], r, c);
        expQ.push_back(e);
      end
    end
    Start     = 1'b1;
    TileReady = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    checkOutput("firstRead", {Busy, BoardRdEn, BoardAddr}, {1'b1, 1'b1, 7'd0});
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge Clock);
      cyc++;
      if (FrameDone) begin
        done = 1'b1;
        checkOutput("frameDoneCycle", 128'(cyc), 128'(400 + stallCycles));
        checkOutput("busyAtFrameDone", {Busy, TileValid}, 2'b00);
        checkOutput("tileCount", 128'(accepted), 128'd100);
        if (BlinkOn) begin
          if (frameCntModel == BlinkFrames - 1) begin
            frameCntModel = 0;
            cursorOnModel = !cursorOnModel;
          end else begin
            frameCntModel++;
          end
        end
      end else if (TileValid) begin
        if (!firstSeen) begin
          firstSeen = 1'b1;
          checkOutput("firstTileLatency", 128'(cyc), 128'd3);
        end
        if (int'(TileRow) == abortRow && int'(TileCol) == abortCol) begin
          TileReady = 1'b0;
          Reset     = 1'b1;
          @(negedge Clock);
          Reset = 1'b0;
          checkOutput("resetMidScan",
                      {BoardRdEn, BoardAddr, RomData, TileValid, TileRow, TileCol, TileDots, FrameDone, Busy},
                      128'd0);
          expQ.delete();
          cursorOnModel = 1'b1;
          frameCntModel = 0;
          done = 1'b1;
        end else if (int'(TileRow) == stallRow && int'(TileCol) == stallCol && stallCnt < stallCycles) begin
          if (stallCnt == 0) held = {TileDots, TileRow, TileCol};
          else checkOutput("stallHold", {TileValid, BoardRdEn, TileDots, TileRow, TileCol}, {1'b1, 1'b0, held});
          TileReady = 1'b0;
          stallCnt++;
        end else begin
          TileReady = 1'b1;
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("tile(%0d,%0d)", e.r, e.c),
                        {RomData, TileRow, TileCol, TileDots}, {e.w, e.r, e.c, romDots(e.w)});
          end
          if (TileRow < 4'd10 && TileCol < 4'd10) seenRom[int'(TileRow)*10 + int'(TileCol)] = RomData;
          accepted++;
        end
      end
    end
    checkOutput("frameTerminated", 128'(done), 128'd1);
    TileReady = 1'b1;
  endtask

  logic [9:0] orAll;
  bit         expOverlay [0:4];

  initial begin
    expOverlay = BlinkOn ? '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1} : '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    Reset     = 1'b1;
    Start     = 1'b0;
    TileReady = 1'b1;
    CursorRow = 4'd10;
    CursorCol = 4'd0;
    cursorOnModel = 1'b1;
    frameCntModel = 0;
    for (int i = 0; i < 100; i++) boardMem[i] = 10'h000;
    repeat (3) @(negedge Clock);
    checkOutput("resetOutputs",
                {BoardRdEn, BoardAddr, RomData, TileValid, TileRow, TileCol, TileDots, FrameDone, Busy},
                128'd0);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("idleAfterReset", {Busy, BoardRdEn, TileValid}, 3'b000);

    // Frame 1: empty board, off-board cursor.
    applyStimulus(-1, -1, 0, -1, -1);
    orAll = '0;
    for (int i = 0; i < 100; i++) orAll = orAll | seenRom[i];
    checkOutput("frame1AllZero", 128'(orAll), 128'd0);
    @(negedge Clock);

    boardMem[34] = 10'h001;
    boardMem[22] = 10'h043;
    boardMem[56] = 10'h0C4;
    CursorRow = 4'd5;
    CursorCol = 4'd6;

    // Frame 2: stall 20 cycles on tile (0,1).
    applyStimulus(0, 1, 20, -1, -1);
    checkOutput("missMarker34", 128'(seenRom[34]), 128'h025);
    checkOutput("passThrough22", 128'(seenRom[22]), 128'h043);
    checkOutput("cursorFrame2", 128'(seenRom[56]), expOverlay[1] ? 128'h0E2 : 128'h0C4);
    @(negedge Clock);

    applyStimulus(-1, -1, 0, -1, -1);
    checkOutput("cursorFrame3", 128'(seenRom[56]), expOverlay[2] ? 128'h0E2 : 128'h0C4);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    checkOutput("startAtFrameDoneIgnored", {Busy, BoardRdEn}, 2'b00);

    applyStimulus(-1, -1, 0, -1, -1);
    checkOutput("cursorFrame4", 128'(seenRom[56]), expOverlay[3] ? 128'h0E2 : 128'h0C4);
    @(negedge Clock);

    applyStimulus(-1, -1, 0, -1, -1);
    checkOutput("cursorFrame5", 128'(seenRom[56]), expOverlay[4] ? 128'h0E2 : 128'h0C4);
    @(negedge Clock);

    // Reset while holding tile (4,4), then a clean restart.
    applyStimulus(-1, -1, 0, 4, 4);
    @(negedge Clock);
    applyStimulus(-1, -1, 0, -1, -1);
    checkOutput("cursorAfterReset", 128'(seenRom[56]), 128'h0E2);
    checkOutput("missAfterReset", 128'(seenRom[34]), 128'h025);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/board_tile_sequencer.md
# board_tile_sequencer

Frame sequencer that walks every cell of one player's board, reads the cell word from board RAM, drives the shared ship-sprite ROM with it, and hands each resulting 8x8 dot-matrix tile to the display driver over a valid/ready handshake. It sits between the board RAM and the ShipROM lookup on one side and the tile/video output stage on the other. It also applies the cursor overlay and the miss-marker substitution before the ROM lookup.

## Interface
Parameters:
- BOARD_DIM, 10: board is BOARD_DIM x BOARD_DIM cells; legal range 1..11.
- BLINK_FRAMES, 16: completed frames per cursor blink half-period; must be ≥1.

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle pulse; begins a frame scan when idle.
- CursorRow  in  4  cursor row, sampled per cell.
- CursorCol  in  4  cursor column, sampled per cell.
- BoardRdEn  out  1  board RAM read strobe.
- BoardAddr  out  7  board RAM address = row*BOARD_DIM + col.
- BoardData  in  10  cell word {ship index[9:6], type[5:1], hit[0]}; valid the cycle after BoardRdEn.
- RomData  out  10  registered ROM index word.
- RomDotMatrix  in  64  combinational ROM result for RomData.
- TileValid  out  1  TileDots/TileRow/TileCol hold a tile.
- TileReady  in  1  consumer accepts the tile when TileValid && TileReady.
- TileRow  out  4  row of the presented tile.
- TileCol  out  4  column of the presented tile.
- TileDots  out  64  registered dot matrix.
- FrameDone  out  1  one-cycle pulse after the last tile is accepted.
- Busy  out  1  high in every state except IDLE.

## Operation
- States are IDLE, READ, WAIT, LOOKUP and HOLD.
- IDLE: Start=1 clears the row and column counters to 0 and moves to READ. Start in any other state is ignored.
- READ: BoardRdEn=1 and BoardAddr=row*BOARD_DIM+col for exactly one cycle, then WAIT.
- WAIT: BoardData is valid. The index word is computed, registered into RomData, and the state moves to LOOKUP.
  - Cursor overlay applies when CursorRow==row, CursorCol==col and CursorOn=1. The result is {BoardData[9:6], 5'b10001, BoardData[0]}.
  - Miss marker applies when there is no cursor overlay, BoardData[5:1]==0 and BoardData[0]=1. The result is {BoardData[9:6], 5'b10010, 1'b1}.
  - Otherwise the result is BoardData unchanged.
  - A cursor coordinate ≥ BOARD_DIM never matches.
- LOOKUP: TileDots←RomDotMatrix, TileRow←row, TileCol←col, TileValid←1, then HOLD.
- HOLD: TileValid and all tile fields stay stable until TileReady=1.
  - On acceptance TileValid←0.
  - If the cell was (BOARD_DIM-1, BOARD_DIM-1): FrameDone=1 for one cycle, update the blink logic, go to IDLE.
  - Otherwise advance col; on col wrap (BOARD_DIM-1→0) advance row. Go to READ.
- Blink logic:
  - frame counter counts 0..BLINK_FRAMES-1 and wraps.
  - CursorOn toggles on each wrap.
- Reset values:
  - state IDLE; row, col and frame counter 0; CursorOn=1.
  - All outputs 0: BoardRdEn, BoardAddr, RomData, TileValid, TileRow, TileCol, TileDots, FrameDone, Busy.
- Reset mid-scan abandons the frame: no FrameDone, and a pending tile is dropped.

## Timing
- Start sampled in cycle N: READ in N+1, WAIT in N+2, LOOKUP in N+3, TileValid=1 from N+4.
- With TileReady held high the peak rate is one tile per 4 cycles. A full 10x10 frame takes 400 cycles from the first READ to FrameDone.
- FrameDone is asserted in the cycle after the final handshake; IDLE is reached in that same cycle. Busy is low that cycle.
- A Start coincident with FrameDone is ignored. A Start one cycle later is accepted.
- Cursor inputs are sampled only in WAIT. Changing them mid-frame affects only cells read afterwards.
- RomDotMatrix is sampled in LOOKUP, one cycle after RomData is updated. The ROM path must settle within one cycle.

## Configuration
- CURSOR_BLINK_EN defined: the blink counter and CursorOn toggling are compiled in as described above.
- Not defined: the blink logic is removed, CursorOn is constant 1, and the cursor overlay appears on every frame. The BLINK_FRAMES parameter is then unused.

## Test plan
- Reset, then Start with all-zero board RAM, TileReady=1: exactly 100 tiles, RomData=10'h000 each, TileRow/TileCol go (0,0)…(9,9) in raster order, FrameDone 400 cycles after the first READ, Busy low after it.
- Cell (3,4)=10'h001 (type 0, hit): the tile for (3,4) has RomData=10'h025 (miss marker). Cell (2,2)=10'h043 passes through unchanged as RomData=10'h043.
- Cursor=(5,6) over cell 10'h0C4: RomData=10'h0E2 for (5,6) only. Cursor=(10,0): no cell substituted.
- TileReady held low for 20 cycles on tile (0,1): TileValid, TileDots and TileCol stay constant, BoardRdEn stays 0, the scan resumes on release, and no tile is duplicated or skipped.
- Reset asserted while in HOLD at (4,4): the next cycle shows all outputs 0, and a following Start restarts at (0,0).
- With CURSOR_BLINK_EN and BLINK_FRAMES=2: the cursor overlay is present in frames 1-2, absent in 3-4, and present in 5. Without the macro it is present in all frames.
